// File: rtl/io_byte_link.sv
// Byte-serial pin link: frames one 32-bit memory request onto an 8-bit pin bus
// and assembles the 4-byte reply for fetch/load, returning a one-cycle response.
module io_byte_link #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    output logic        rsp_err,
    output logic [7:0]  pin_out,
    output logic        pin_strobe,
    input  logic [7:0]  pin_in,
    input  logic        pin_in_valid,
    output logic        busy
);

    localparam int unsigned CNT_W = 2;
    localparam int unsigned TMO_W = 16;
    localparam logic [1:0]  OP_STORE   = 2'b10;
    localparam logic [1:0]  OP_ILLEGAL = 2'b11;
    localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HDR   = 3'd1,
        ADDR  = 3'd2,
        WDATA = 3'd3,
        RDATA = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic [TMO_W-1:0]   tmo_inc;
    logic [1:0]         op_q, op_d;
    logic [31:0]        addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [31:0]        rbuf_q, rbuf_d;
    logic [4:0]         rshift;
    logic               rsp_valid_d, rsp_err_d, pin_strobe_d, busy_d;
    logic [31:0]        rsp_data_d;
    logic [7:0]         pin_out_d;

    assign req_ready = (state_q == IDLE);
    assign tmo_inc   = tmo_q + TMO_W'(1);
    assign rshift    = {cnt_q, 3'b000};

    // State register and all registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            tmo_q      <= '0;
            op_q       <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rbuf_q     <= '0;
            rsp_valid  <= 1'b0;
            rsp_data   <= '0;
            rsp_err    <= 1'b0;
            pin_out    <= '0;
            pin_strobe <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            tmo_q      <= tmo_d;
            op_q       <= op_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rbuf_q     <= rbuf_d;
            rsp_valid  <= rsp_valid_d;
            rsp_data   <= rsp_data_d;
            rsp_err    <= rsp_err_d;
            pin_out    <= pin_out_d;
            pin_strobe <= pin_strobe_d;
            busy       <= busy_d;
        end
    end

    // Next-state logic; pin values are computed for the state being entered
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        tmo_d        = tmo_q;
        op_d         = op_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rbuf_d       = rbuf_q;
        rsp_valid_d  = 1'b0;
        rsp_data_d   = rsp_data;
        rsp_err_d    = rsp_err;
        pin_out_d    = pin_out;
        pin_strobe_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    op_d    = req_op;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    if (req_op == OP_ILLEGAL) begin
                        state_d     = DONE;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_data_d  = '0;
                    end else begin
                        state_d      = HDR;
                        pin_out_d    = {4'hA, 2'b00, req_op};
                        pin_strobe_d = 1'b1;
                    end
                end
            end
            HDR: begin
                state_d      = ADDR;
                cnt_d        = '0;
                pin_out_d    = addr_q[7:0];
                pin_strobe_d = 1'b1;
            end
            ADDR: begin
                if (cnt_q == CNT_W'(3)) begin
                    cnt_d = '0;
                    tmo_d = '0;
                    if (op_q == OP_STORE) begin
                        state_d      = WDATA;
                        pin_out_d    = wdata_q[7:0];
                        pin_strobe_d = 1'b1;
                    end else begin
                        state_d = RDATA;
                    end
                end else begin
                    cnt_d        = cnt_q + CNT_W'(1);
                    pin_out_d    = 8'(addr_q >> {cnt_d, 3'b000});
                    pin_strobe_d = 1'b1;
                end
            end
            WDATA: begin
                if (cnt_q == CNT_W'(3)) begin
                    cnt_d       = '0;
                    state_d     = DONE;
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = '0;
                    rsp_err_d   = 1'b0;
                end else begin
                    cnt_d        = cnt_q + CNT_W'(1);
                    pin_out_d    = 8'(wdata_q >> {cnt_d, 3'b000});
                    pin_strobe_d = 1'b1;
                end
            end
            RDATA: begin
                // A reply byte beats a timeout landing in the same cycle
                if (pin_in_valid) begin
                    rbuf_d = (rbuf_q & ~(32'h0000_00FF << rshift)) | (32'(pin_in) << rshift);
                    tmo_d  = '0;
                    if (cnt_q == CNT_W'(3)) begin
                        cnt_d       = '0;
                        state_d     = DONE;
                        rsp_valid_d = 1'b1;
                        rsp_data_d  = rbuf_d;
                        rsp_err_d   = 1'b0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else if (tmo_inc == TMO_LIMIT) begin
                    tmo_d       = '0;
                    cnt_d       = '0;
                    state_d     = DONE;
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = 32'hFFFF_FFFF;
                    rsp_err_d   = 1'b1;
                end else begin
                    tmo_d = tmo_inc;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

endmodule

// File: tb/tb_io_byte_link.sv
// Bench for io_byte_link: two instances (default timeout and a short one) share
// stimulus; each cycle is compared against a transaction-level reference model.
module tb_io_byte_link;

    localparam int MAXC = 600;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic [1:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [7:0]  pin_in;
    logic        pin_in_valid;

    logic        rdy_w   [2];
    logic        vld_w   [2];
    logic [31:0] data_w  [2];
    logic        err_w   [2];
    logic [7:0]  pout_w  [2];
    logic        strb_w  [2];
    logic        busy_w  [2];

    int          tests = 0;
    int          fails = 0;
    int          tmo_of [2];
    logic        sched_v [MAXC];
    logic [7:0]  sched_b [MAXC];
    logic [7:0]  last_pin;

    always #5 clk = ~clk;

    io_byte_link #(.TIMEOUT_CYCLES(255)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy_w[0]),
        .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(vld_w[0]), .rsp_data(data_w[0]), .rsp_err(err_w[0]),
        .pin_out(pout_w[0]), .pin_strobe(strb_w[0]), .pin_in(pin_in),
        .pin_in_valid(pin_in_valid), .busy(busy_w[0])
    );

    io_byte_link #(.TIMEOUT_CYCLES(4)) dut_t (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy_w[1]),
        .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(vld_w[1]), .rsp_data(data_w[1]), .rsp_err(err_w[1]),
        .pin_out(pout_w[1]), .pin_strobe(strb_w[1]), .pin_in(pin_in),
        .pin_in_valid(pin_in_valid), .busy(busy_w[1])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_sched();
        for (int c = 0; c < MAXC; c++) begin
            sched_v[c] = 1'b0;
            sched_b[c] = 8'h00;
        end
    endtask

    // Reference: completion cycle (relative to accept), reply word and error flag
    function automatic void model(input int t, input logic [1:0] op, output int done,
                                  output logic [31:0] data, output logic err);
        int got;
        int idle;
        data = 32'h0;
        err  = 1'b0;
        done = 0;
        got  = 0;
        idle = 0;
        if (op == 2'b11) begin
            done = 1;
            err  = 1'b1;
        end else if (op == 2'b10) begin
            done = 10;
        end else begin
            for (int c = 6; c < MAXC - 2 && done == 0; c++) begin
                if (sched_v[c]) begin
                    data[8*got +: 8] = sched_b[c];
                    got++;
                    idle = 0;
                    if (got == 4) done = c + 1;
                end else begin
                    idle++;
                    if (idle == t) begin
                        done = c + 1;
                        err  = 1'b1;
                        data = 32'hFFFF_FFFF;
                    end
                end
            end
        end
    endfunction

    task automatic run_txn(input string name, input logic [1:0] op,
                           input logic [31:0] addr, input logic [31:0] wdata);
        int          done [2];
        logic [31:0] edata [2];
        logic        eerr [2];
        int          last;
        logic        strb;
        logic [7:0]  b;
        for (int i = 0; i < 2; i++) model(tmo_of[i], op, done[i], edata[i], eerr[i]);
        last = ((done[0] > done[1]) ? done[0] : done[1]) + 1;
        for (int i = 0; i < 2; i++)
            chk($sformatf("%s.i%0d.ready_c0", name, i), 32'(rdy_w[i]), 32'd1);
        req_valid    = 1'b1;
        req_op       = op;
        req_addr     = addr;
        req_wdata    = wdata;
        pin_in_valid = sched_v[0];
        pin_in       = sched_b[0];
        for (int c = 1; c <= last; c++) begin
            step();
            req_valid = 1'b0;
            strb = 1'b0;
            b    = 8'h00;
            if (op != 2'b11) begin
                if (c == 1) begin
                    strb = 1'b1; b = {4'hA, 2'b00, op};
                end else if (c <= 5) begin
                    strb = 1'b1; b = 8'(addr >> (8 * (c - 2)));
                end else if (op == 2'b10 && c <= 9) begin
                    strb = 1'b1; b = 8'(wdata >> (8 * (c - 6)));
                end
            end
            if (strb) last_pin = b;
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("%s.c%0d.i%0d.strobe", name, c, i), 32'(strb_w[i]), 32'(strb));
                chk($sformatf("%s.c%0d.i%0d.pin", name, c, i), 32'(pout_w[i]), 32'(last_pin));
                chk($sformatf("%s.c%0d.i%0d.rsp_valid", name, c, i), 32'(vld_w[i]), 32'(c == done[i]));
                chk($sformatf("%s.c%0d.i%0d.busy", name, c, i), 32'(busy_w[i]), 32'(c <= done[i]));
                chk($sformatf("%s.c%0d.i%0d.ready", name, c, i), 32'(rdy_w[i]), 32'(c > done[i]));
                if (c == done[i])
                    chk($sformatf("%s.c%0d.i%0d.err", name, c, i), 32'(err_w[i]), 32'(eerr[i]));
                if (c >= done[i] && op != 2'b11)
                    chk($sformatf("%s.c%0d.i%0d.data", name, c, i), data_w[i], edata[i]);
            end
            pin_in_valid = sched_v[c];
            pin_in       = sched_b[c];
        end
        pin_in_valid = 1'b0;
    endtask

    task automatic chk_idle_reset(input string name);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("%s.i%0d.ready", name, i), 32'(rdy_w[i]), 32'd1);
            chk($sformatf("%s.i%0d.busy", name, i), 32'(busy_w[i]), 32'd0);
            chk($sformatf("%s.i%0d.rsp_valid", name, i), 32'(vld_w[i]), 32'd0);
            chk($sformatf("%s.i%0d.rsp_err", name, i), 32'(err_w[i]), 32'd0);
            chk($sformatf("%s.i%0d.rsp_data", name, i), data_w[i], 32'd0);
            chk($sformatf("%s.i%0d.pin_out", name, i), 32'(pout_w[i]), 32'd0);
            chk($sformatf("%s.i%0d.strobe", name, i), 32'(strb_w[i]), 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int g;
        tmo_of[0]    = 255;
        tmo_of[1]    = 4;
        rst          = 1'b1;
        req_valid    = 1'b0;
        req_op       = 2'b00;
        req_addr     = 32'h0;
        req_wdata    = 32'h0;
        pin_in       = 8'h00;
        pin_in_valid = 1'b0;
        last_pin     = 8'h00;
        clear_sched();
        step();
        step();
        chk_idle_reset("reset");
        rst = 1'b0;
        step();

        // Store 0x12345678 / 0xCAFEBABE
        clear_sched();
        run_txn("store", 2'b10, 32'h1234_5678, 32'hCAFE_BABE);

        // Fetch with back-to-back reply bytes
        clear_sched();
        sched_v[6] = 1'b1; sched_b[6] = 8'h13;
        sched_v[7] = 1'b1; sched_b[7] = 8'h00;
        sched_v[8] = 1'b1; sched_b[8] = 8'h08;
        sched_v[9] = 1'b1; sched_b[9] = 8'h20;
        run_txn("fetch", 2'b00, 32'h0000_0004, $urandom);

        // Load with gapped reply bytes; noise before RDATA is ignored
        clear_sched();
        sched_v[2]  = 1'b1; sched_b[2]  = 8'hEE;
        sched_v[8]  = 1'b1; sched_b[8]  = 8'h11;
        sched_v[12] = 1'b1; sched_b[12] = 8'h22;
        sched_v[13] = 1'b1; sched_b[13] = 8'h33;
        sched_v[20] = 1'b1; sched_b[20] = 8'h44;
        run_txn("gapped", 2'b01, 32'h0000_1000, 32'h0);

        // One byte then silence; late bytes only matter to the long-timeout link
        clear_sched();
        sched_v[6]  = 1'b1; sched_b[6]  = 8'h5A;
        sched_v[12] = 1'b1; sched_b[12] = 8'h6B;
        sched_v[13] = 1'b1; sched_b[13] = 8'h7C;
        sched_v[40] = 1'b1; sched_b[40] = 8'h8D;
        run_txn("timeout", 2'b01, 32'h0000_2000, 32'h0);

        // Illegal op
        clear_sched();
        sched_v[0] = 1'b1; sched_b[0] = 8'h99;
        sched_v[1] = 1'b1; sched_b[1] = 8'h98;
        run_txn("illegal", 2'b11, 32'hDEAD_BEEF, 32'h0BAD_F00D);

        // Randomized mix of ops and reply timing
        for (int n = 0; n < 20; n++) begin
            clear_sched();
            for (int c = 0; c < 6; c++) begin
                sched_v[c] = 1'($urandom_range(0, 1));
                sched_b[c] = 8'($urandom);
            end
            g = 6;
            for (int k = 0; k < 6; k++) begin
                g = g + int'($urandom_range(0, 6));
                sched_v[g] = 1'b1;
                sched_b[g] = 8'($urandom);
                g = g + 1;
            end
            run_txn($sformatf("rand%0d", n), 2'($urandom_range(0, 3)), $urandom, $urandom);
        end

        // Load that leaves non-zero data, then reset during address byte 2
        clear_sched();
        for (int c = 6; c < 10; c++) begin
            sched_v[c] = 1'b1;
            sched_b[c] = 8'($urandom_range(1, 255));
        end
        run_txn("preload", 2'b01, $urandom, 32'h0);
        req_valid = 1'b1;
        req_op    = 2'b10;
        req_addr  = 32'hA1B2_C3D4;
        req_wdata = 32'h0102_0304;
        for (int c = 1; c <= 4; c++) begin
            step();
            req_valid = 1'b0;
        end
        for (int i = 0; i < 2; i++)
            chk($sformatf("rst_mid.i%0d.pin_before", i), 32'(pout_w[i]), 32'h0000_00B2);
        rst = 1'b1;
        #1;
        chk_idle_reset("rst_mid");
        step();
        rst = 1'b0;
        last_pin = 8'h00;
        for (int c = 0; c < 12; c++) begin
            step();
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("post_rst.c%0d.i%0d.rsp_valid", c, i), 32'(vld_w[i]), 32'd0);
                chk($sformatf("post_rst.c%0d.i%0d.busy", c, i), 32'(busy_w[i]), 32'd0);
            end
        end

        clear_sched();
        run_txn("store_after_rst", 2'b10, $urandom, $urandom);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/io_byte_link.md
# io_byte_link

Byte-serial pin link sitting directly downstream of the IO controller, between it and the 8-bit TinyTapeOut pins. It accepts one 32-bit memory transaction at a time (instruction fetch, load, store) over a valid/ready handshake. It serializes a framed request onto the output pins and deserializes the 4-byte reply for fetch/load. It returns a single-cycle response with data or an error flag.

## Interface
- TIMEOUT_CYCLES, 255: max consecutive RDATA cycles without a reply byte before aborting; legal range 1..65535.
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE; combinational from state.
- req_op  in  2  00 fetch, 01 load, 10 store, 11 illegal.
- req_addr  in  32  byte address; sampled on accept.
- req_wdata  in  32  store data; sampled on accept.
- rsp_valid  out  1  one-cycle pulse: transaction complete.
- rsp_data  out  32  reply word; holds until next rsp_valid.
- rsp_err  out  1  valid with rsp_valid; 1 = timeout or illegal op.
- pin_out  out  8  outgoing byte, registered.
- pin_strobe  out  1  pin_out carries a valid byte this cycle, registered.
- pin_in  in  8  incoming reply byte.
- pin_in_valid  in  1  pin_in valid this cycle.
- busy  out  1  state != IDLE.

## Operation
- States: IDLE, HDR, ADDR, WDATA, RDATA, DONE. A 2-bit byte counter and a 16-bit timeout counter.
- IDLE: req_ready=1. Accept on req_valid&&req_ready; latch op, addr, and wdata. Op 11 goes to DONE with err=1 and no pin activity. Other ops go to HDR.
- HDR: drive header byte {4'hA, 2'b00, op}. Go to ADDR with cnt=0.
- ADDR: drive req_addr[8*cnt +: 8], LSB first, 4 cycles. After cnt=3: store goes to WDATA; fetch/load go to RDATA. cnt=0 and timeout=0 on exit.
- WDATA: drive req_wdata bytes LSB first, 4 cycles. Then DONE with rsp_data=0 and err=0.
- RDATA: pin_strobe=0. On pin_in_valid, write pin_in into rsp_data[8*cnt +: 8], increment cnt, and clear the timeout counter. After the 4th byte, go to DONE with err=0.
  - Without pin_in_valid, timeout increments. When it reaches TIMEOUT_CYCLES, go to DONE with err=1 and rsp_data=32'hFFFF_FFFF.
- DONE: rsp_valid=1 for exactly one cycle, then IDLE.
- pin_in_valid outside RDATA is ignored; no capture.
- Byte counter wraps 3→0 only on state exit; never counts past 3 within a state.

## Timing
- Reset values: req_ready=1 (IDLE), busy=0, rsp_valid=0, rsp_err=0, rsp_data=0, pin_out=0, pin_strobe=0.
- Accept at cycle 0. Header appears on pins at cycle 1. Address bytes appear at cycles 2-5.
- Store: data bytes at cycles 6-9; rsp_valid at cycle 10; req_ready again at cycle 11. Total 11 cycles per store.
- Fetch/load: RDATA entered at cycle 6. A reply byte present at cycle 6 is captured. With back-to-back reply bytes at cycles 6-9, rsp_valid is at cycle 10.
- In RDATA, a byte arriving in the same cycle the timeout would fire wins: it is captured, and the timeout is cleared.
- pin_strobe is high in HDR/ADDR/WDATA only. pin_out holds its last value when the strobe is low.
- Asserting rst mid-transaction immediately aborts to IDLE with no rsp_valid. Partially captured data is cleared to 0.
- req_valid while busy is not accepted. The requester must hold req_valid and its request until req_ready.

## Test plan
- Store op=10, addr=0x12345678, wdata=0xCAFEBABE -> pins 0xA2,78,56,34,12,BE,BA,FE,CA at cycles 1-9; rsp_valid cycle 10, rsp_data=0, err=0.
- Fetch op=00, addr=0x00000004; reply bytes 0x13,0x00,0x08,0x20 at cycles 6-9 -> header 0xA0; rsp_data=0x20080013 at cycle 10.
- Load with reply bytes gapped (cycles 8, 12, 13, 20) -> rsp_data assembled LSB-first; rsp_valid the cycle after the last byte; no timeout.
- Load with TIMEOUT_CYCLES=4 and one reply byte then silence -> rsp_err=1 and rsp_data=0xFFFFFFFF after 4 idle cycles; pin_in_valid afterwards is ignored.
- Illegal op=11 -> no pin_strobe; rsp_valid with err=1 at cycle 1; req_ready at cycle 2.
- rst asserted during ADDR byte 2 -> next cycle IDLE, pin_strobe=0, no rsp_valid; a subsequent store completes normally.
